debug_ring_segment: RTL and testbench

- Parametrised, buffered DII ring segment: a chain of PORTS router stations, each with one local debug-module port (HIM, SCM, DEM, MAM, ...).
- Routes packets by destination ID, with packet-atomic round-robin arbitration between ring traffic and local injection.
- Supersedes the fixed, unbuffered ring inside the debug system. Segments chain ring_out to ring_in; the top level closes the loop.

---
 rtl/debug_ring_segment.sv | 134 +++++++++++++
 tb/tb_debug_ring_segment.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_ring_segment.sv
// Buffered DII ring segment: PORTS router stations in a chain, each with an input FIFO,
// a destination-ID route FSM and a packet-atomic round-robin arbiter for local injection.
module debug_ring_segment #(
    parameter int PORTS      = 4,
    parameter int BUF_DEPTH  = 4,
    parameter int ID_WIDTH   = 10,
    parameter int ID_BASE    = 0,
    parameter int DATA_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [DATA_WIDTH+1:0]              ring_in,
    output logic                               ring_in_ready,
    output logic [DATA_WIDTH+1:0]              ring_out,
    input  logic                               ring_out_ready,
    input  logic [PORTS-1:0][DATA_WIDTH+1:0]   local_in,
    output logic [PORTS-1:0]                   local_in_ready,
    output logic [PORTS-1:0][DATA_WIDTH+1:0]   local_out,
    input  logic [PORTS-1:0]                   local_out_ready
);
    // Flit layout: {valid, last, data}
    localparam int FW = DATA_WIDTH + 2;
    localparam int SW = DATA_WIDTH + 1;
    localparam int AW = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_DELIVER, R_FORWARD} route_t;
    typedef enum logic [1:0] {A_IDLE, A_RING, A_LOCAL} arb_t;

    logic [PORTS:0][FW-1:0] link;
    logic [PORTS:0]         link_ready;

    assign link[0]           = ring_in;
    assign ring_in_ready     = link_ready[0];
    assign ring_out          = link[PORTS];
    assign link_ready[PORTS] = ring_out_ready;

    for (genvar i = 0; i < PORTS; i++) begin : g_st
        localparam logic [ID_WIDTH-1:0] MY_ID = ID_WIDTH'(ID_BASE + i);

        logic [SW-1:0]         mem [BUF_DEPTH];
        logic [AW-1:0]         wptr, rptr;
        logic [AW:0]           count;
        logic                  full, head_valid, push, pop;
        logic [SW-1:0]         head;
        route_t                route_q, route_d, route_eff;
        arb_t                  arb_q, arb_d;
        logic                  ptr_q, ptr_d;
        logic                  deliver, fwd_valid, lin_valid;
        logic                  sel_ring, sel_local, out_valid, out_last, xfer;
        logic [DATA_WIDTH-1:0] out_data;

        // Ready is registered-only so no ready path spans more than one station.
        assign full          = (count == (AW+1)'(BUF_DEPTH));
        assign head_valid    = (count != '0);
        assign link_ready[i] = !full;
        assign push          = link[i][FW-1] && !full;
        assign head          = mem[rptr];

        always_ff @(posedge clk) begin
            if (push) mem[wptr] <= link[i][SW-1:0];
        end

        // Route decision applies to the head in the same cycle it becomes visible.
        always_comb begin
            route_eff = route_q;
            if (route_q == R_IDLE)
                route_eff = (head[ID_WIDTH-1:0] == MY_ID) ? R_DELIVER : R_FORWARD;
        end

        assign deliver   = head_valid && (route_eff == R_DELIVER);
        assign fwd_valid = head_valid && (route_eff == R_FORWARD);
        assign lin_valid = local_in[i][FW-1];
        assign local_out[i] = {deliver, head};

        always_comb begin
            sel_ring  = 1'b0;
            sel_local = 1'b0;
            case (arb_q)
                A_RING:  sel_ring  = 1'b1;
                A_LOCAL: sel_local = 1'b1;
                default: begin
                    if (fwd_valid && lin_valid) begin
                        sel_ring  = !ptr_q;
                        sel_local = ptr_q;
                    end else begin
                        sel_ring  = fwd_valid;
                        sel_local = lin_valid;
                    end
                end
            endcase
        end

        assign out_valid = (sel_ring && fwd_valid) || (sel_local && lin_valid);
        assign out_last  = sel_ring ? head[DATA_WIDTH] : local_in[i][FW-2];
        assign out_data  = sel_ring ? head[DATA_WIDTH-1:0] : local_in[i][DATA_WIDTH-1:0];
        assign link[i+1] = {out_valid, out_last, out_data};
        assign xfer      = out_valid && link_ready[i+1];
        assign local_in_ready[i] = sel_local && link_ready[i+1];
        assign pop = (deliver && local_out_ready[i]) ||
                     (sel_ring && fwd_valid && link_ready[i+1]);

        always_comb begin
            route_d = route_q;
            arb_d   = arb_q;
            ptr_d   = ptr_q;
            if (pop)
                route_d = head[DATA_WIDTH] ? R_IDLE : route_eff;
            if (xfer) begin
                arb_d = out_last ? A_IDLE : (sel_ring ? A_RING : A_LOCAL);
                // The pointer only turns on a contended grant, so the loser goes first next time.
                if (arb_q == A_IDLE && fwd_valid && lin_valid)
                    ptr_d = sel_ring;
            end
        end

        always_ff @(posedge clk) begin
            if (!rstn) begin
                wptr    <= '0;
                rptr    <= '0;
                count   <= '0;
                route_q <= R_IDLE;
                arb_q   <= A_IDLE;
                ptr_q   <= 1'b0;
            end else begin
                if (push) wptr <= wptr + AW'(1);
                if (pop)  rptr <= rptr + AW'(1);
                count   <= count + (AW+1)'(push) - (AW+1)'(pop);
                route_q <= route_d;
                arb_q   <= arb_d;
                ptr_q   <= ptr_d;
            end
        end
    end
endmodule

// File: tb/tb_debug_ring_segment.sv
// Bench for debug_ring_segment: per-(output,source) flit queues predicted from the routing
// rules, checked on every output transfer, plus directed latency/arbitration/backpressure cases.
module tb_debug_ring_segment;
    localparam int P  = 4;
    localparam int NS = P + 1;          // sources/outputs: 0..P-1 local, P = ring
    localparam int NQ = NS * NS;
    localparam int DW = 16;
    localparam int FW = DW + 2;
    localparam int IW = 10;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [FW-1:0]         ring_in = '0;
    logic                  ring_in_ready;
    logic [FW-1:0]         ring_out;
    logic                  ring_out_ready = 1'b1;
    logic [P-1:0][FW-1:0]  local_in = '0;
    logic [P-1:0]          local_in_ready;
    logic [P-1:0][FW-1:0]  local_out;
    logic [P-1:0]          local_out_ready = '1;

    always #5 clk = ~clk;

    debug_ring_segment #(.PORTS(P), .BUF_DEPTH(4), .ID_WIDTH(IW), .ID_BASE(0), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rstn(rstn),
        .ring_in(ring_in), .ring_in_ready(ring_in_ready),
        .ring_out(ring_out), .ring_out_ready(ring_out_ready),
        .local_in(local_in), .local_in_ready(local_in_ready),
        .local_out(local_out), .local_out_ready(local_out_ready)
    );

    typedef struct { int o; int s; int cyc; bit last; } ev_t;

    int checks = 0, errors = 0, cyc = 0, ring_acc = 0;
    bit rnd = 1'b0;
    logic [P-1:0] lo_rdy_fix = '1;
    logic [DW:0] sq [NS][$];
    logic [DW:0] expq [NQ][$];
    bit hold [NS], xfer [NS], src_inpkt [NS], out_inpkt [NS];
    int src_out [NS], out_src [NS];
    ev_t evlog [$];
    int ids [8] = '{0, 1, 2, 3, 4, 9, 1023, 2};

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Destination output of a packet from source s: stations downstream of the source
    // deliver their own ID, everything else leaves on ring_out.
    function automatic int route(int s, logic [IW-1:0] id);
        int d = int'(id);
        if (d < P && (s == P || d > s)) return d;
        return P;
    endfunction

    function automatic int pending_src();
        int n = 0;
        for (int s = 0; s < NS; s++) n += sq[s].size();
        return n;
    endfunction

    function automatic int pending_exp();
        int n = 0;
        for (int q = 0; q < NQ; q++) n += expq[q].size();
        return n;
    endfunction

    task automatic make_pkt(int s, int id, int len);
        for (int k = 0; k < len; k++) begin
            logic [DW:0] f;
            f[DW]         = (k == len - 1);
            f[DW-1:DW-4]  = 4'(s);
            f[11:0]       = (k == 0) ? {2'b00, 10'(id)} : 12'($urandom);
            sq[s].push_back(f);
        end
    endtask

    task automatic monitor();
        logic [FW-1:0] fl;
        logic rdy;
        int s, q;
        if (!rstn) begin
            for (int k = 0; k < NQ; k++) expq[k].delete();
            for (int k = 0; k < NS; k++) begin
                src_inpkt[k] = 0; out_inpkt[k] = 0; xfer[k] = 0;
            end
            return;
        end
        for (int si = 0; si < NS; si++) begin
            fl = (si == P) ? ring_in : local_in[si];
            rdy = (si == P) ? ring_in_ready : local_in_ready[si];
            xfer[si] = fl[FW-1] && rdy;
            if (xfer[si]) begin
                if (si == P) ring_acc++;
                if (!src_inpkt[si]) src_out[si] = route(si, fl[IW-1:0]);
                expq[src_out[si]*NS + si].push_back(fl[DW:0]);
                src_inpkt[si] = !fl[DW];
            end
        end
        for (int o = 0; o < NS; o++) begin
            fl = (o == P) ? ring_out : local_out[o];
            rdy = (o == P) ? ring_out_ready : local_out_ready[o];
            if (fl[FW-1] && rdy) begin
                s = int'(fl[DW-1:DW-4]);
                evlog.push_back('{o, s, cyc, fl[DW]});
                checks++;
                if (s >= NS) begin
                    errors++;
                    $display("FAIL out%0d_src: got %0d expected below %0d", o, s, NS);
                end else begin
                    q = o*NS + s;
                    if (out_inpkt[o] && out_src[o] != s) begin
                        errors++;
                        $display("FAIL out%0d_interleave: got src %0d expected src %0d", o, s, out_src[o]);
                    end else if (expq[q].size() == 0) begin
                        errors++;
                        $display("FAIL out%0d_unexpected: got %h expected no flit", o, fl[DW:0]);
                    end else if (expq[q][0] !== fl[DW:0]) begin
                        errors++;
                        $display("FAIL out%0d_flit: got %h expected %h", o, fl[DW:0], expq[q][0]);
                    end
                    if (expq[q].size() > 0) void'(expq[q].pop_front());
                end
                out_inpkt[o] = !fl[DW];
                out_src[o]   = s;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int s = 0; s < NS; s++) begin
            logic [FW-1:0] fl;
            if (xfer[s] && sq[s].size() > 0) begin
                void'(sq[s].pop_front());
                hold[s] = 0;
            end
            fl = '0;
            if (sq[s].size() > 0 && (hold[s] || !rnd || $urandom_range(3) != 0)) begin
                fl = {1'b1, sq[s][0]};
                hold[s] = 1;
            end
            if (s == P) ring_in = fl;
            else local_in[s] = fl;
        end
        ring_out_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
        for (int k = 0; k < P; k++)
            local_out_ready[k] = rnd ? ($urandom_range(3) != 0) : lo_rdy_fix[k];
        @(negedge clk);
        monitor();
    endtask

    task automatic do_reset(int n);
        rstn = 1'b0;
        for (int s = 0; s < NS; s++) begin
            sq[s].delete(); hold[s] = 0; xfer[s] = 0;
        end
        repeat (n) step();
        rstn = 1'b1;
    endtask

    function automatic int out_valids();
        int v = int'(ring_out[FW-1]);
        for (int k = 0; k < P; k++) v += int'(local_out[k][FW-1]);
        return v;
    endfunction

    initial begin
        int c0, n;
        // reset state
        do_reset(3);
        step();
        chk("rst_ring_in_ready", ring_in_ready, 1);
        chk("rst_out_valids", out_valids(), 0);
        chk("rst_local_in_ready", local_in_ready, 0);
        make_pkt(P, 9, 4);
        step();
        chk("rst_first_flit_ready", ring_in_ready, 1);
        chk("rst_first_flit_outputs", out_valids(), 0);
        do_reset(2);

        // delivery to station 2
        evlog.delete(); make_pkt(P, 2, 3); step(); c0 = cyc; repeat (10) step();
        chk("dlv_count", evlog.size(), 3);
        for (int k = 0; k < 3 && k < evlog.size(); k++) begin
            chk("dlv_port", evlog[k].o, 2);
            chk("dlv_cycle", evlog[k].cyc - c0, 3 + k);
            chk("dlv_last", evlog[k].last, k == 2);
        end

        // pass-through of an out-of-segment ID
        evlog.delete(); make_pkt(P, 9, 3); step(); c0 = cyc; repeat (10) step();
        chk("pass_count", evlog.size(), 3);
        for (int k = 0; k < 3 && k < evlog.size(); k++) begin
            chk("pass_port", evlog[k].o, P);
            chk("pass_cycle", evlog[k].cyc - c0, 4 + k);
        end

        // local injection latency; own ID goes out, never looped back locally
        evlog.delete(); make_pkt(1, 9, 1); step(); c0 = cyc; repeat (6) step();
        chk("inj1_count", evlog.size(), 1);
        if (evlog.size() > 0) chk("inj1_cycle", evlog[0].cyc - c0, 2);
        evlog.delete(); make_pkt(3, 3, 1); step(); c0 = cyc; repeat (4) step();
        chk("inj3_count", evlog.size(), 1);
        if (evlog.size() > 0) begin
            chk("inj3_port", evlog[0].o, P);
            chk("inj3_cycle", evlog[0].cyc - c0, 0);
        end

        // two rounds of contention at station 1: ring first, then local first
        for (int r = 0; r < 2; r++) begin
            evlog.delete();
            make_pkt(P, 9, 4); step(); step();
            make_pkt(1, 9, 4); repeat (20) step();
            chk("cont_count", evlog.size(), 8);
            for (int k = 0; k < 8 && k < evlog.size(); k++)
                chk("cont_order", evlog[k].s, ((k < 4) == (r == 0)) ? P : 1);
        end

        // backpressure from a stalled local consumer
        evlog.delete(); lo_rdy_fix[0] = 1'b0; n = ring_acc;
        make_pkt(P, 0, 6); repeat (10) step();
        chk("bp_accepted", ring_acc - n, 4);
        chk("bp_ring_in_ready", ring_in_ready, 0);
        chk("bp_no_delivery", evlog.size(), 0);
        lo_rdy_fix[0] = 1'b1; repeat (12) step();
        chk("bp_drained", evlog.size(), 6);
        if (evlog.size() == 6) chk("bp_last", evlog[5].last, 1);

        // reset after 2 of 4 flits accepted
        make_pkt(P, 3, 4); repeat (3) step();
        do_reset(2);
        evlog.delete(); repeat (10) step();
        chk("rstmid_no_output", evlog.size(), 0);
        chk("rstmid_ring_in_ready", ring_in_ready, 1);
        chk("rstmid_scoreboard_empty", pending_exp(), 0);

        // randomized traffic with random bubbles and backpressure
        rnd = 1'b1;
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < 20; k++)
                make_pkt(s, ids[$urandom_range(0, 7)], $urandom_range(1, 5));
        n = 0;
        while (pending_src() > 0 && n < 4000) begin step(); n++; end
        chk("rand_sources_done", pending_src(), 0);
        rnd = 1'b0; n = 0;
        while (pending_exp() > 0 && n < 300) begin step(); n++; end
        chk("rand_drained", pending_exp(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
